// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit unsigned subtractor. Computes diff = a - b one bit
//   per clock, LSB first, with a single full-subtractor cell and a borrow
//   flip-flop, behind a start/done handshake.
//
// Ports
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   start   begin a subtraction (only honoured while idle)
//   a, b    minuend / subtrahend, captured on the accepting edge
//   busy    high while a subtraction is in progress
//   done    one-cycle pulse; diff/borrow valid from this cycle
//   diff    a - b modulo 2^WIDTH, held until the next completion
//   borrow  final borrow out (1 when a < b), held with diff

module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             borrow_ff;
    logic [CW-1:0]    count;

    // Full-subtractor cell on the current LSBs.
    logic x, y, d, br_next;

    always_comb begin
        x       = sa[0];
        y       = sb[0];
        d       = x ^ y ^ borrow_ff;
        br_next = (~x & y) | (~(x ^ y) & borrow_ff);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            sa        <= '0;
            sb        <= '0;
            sd        <= '0;
            borrow_ff <= 1'b0;
            count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa        <= a;
                        sb        <= b;
                        sd        <= '0;
                        borrow_ff <= 1'b0;
                        count     <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa        <= sa >> 1;
                    sb        <= sb >> 1;
                    sd        <= {d, sd[WIDTH-1:1]};
                    borrow_ff <= br_next;
                    count     <= count + 1'b1;
                    // Final bit: publish the result directly, including the
                    // bit being computed this edge.
                    if (count == LAST) begin
                        diff   <= {d, sd[WIDTH-1:1]};
                        borrow <= br_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int accept_cnt = 0;
    int cyc = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
    } exp_t;

    exp_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   full;
        full = int'(x) - int'(y);
        e.d  = W'(full + (1 << W));
        e.br = (int'(x) < int'(y));
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) begin
            exp_t e;
            check("done_pulse_width", {31'b0, prev_done}, 32'd0);
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 diff=%0h expected no pending op", diff);
            end else begin
                e = exp_q.pop_front();
                check("diff", {24'b0, diff}, {24'b0, e.d});
                check("borrow", {31'b0, borrow}, {31'b0, e.br});
            end
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue an operation; returns one cycle after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_idle();
        start = 1'b1;
        a     = x;
        b     = y;
        exp_q.push_back(model(x, y));
        accept_cnt++;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int c1;
        resetn = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_diff", {24'b0, diff}, 32'd0);
        check("rst_borrow", {31'b0, borrow}, 32'd0);
        resetn = 1'b1;
        tick();

        // Basic op with busy duration and done width.
        issue(8'h5A, 8'h3C);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("busy_cycles", n, 32'd8);
        check("done_after_busy", {31'b0, done}, 32'd1);
        tick();
        check("done_low_after", {31'b0, done}, 32'd0);

        issue(8'h10, 8'h20);
        issue(8'h00, 8'h01);
        issue(8'hFF, 8'hFF);
        issue(8'h80, 8'h00);
        wait_idle();

        // Start while busy is ignored.
        issue(8'h33, 8'h11);
        tick();
        start = 1'b1;
        a     = 8'h00;
        b     = 8'hFF;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (3) tick();

        // Back-to-back with start held high.
        start = 1'b1;
        a     = 8'h09;
        b     = 8'h04;
        exp_q.push_back(model(8'h09, 8'h04));
        accept_cnt++;
        tick();
        wait_done(n);
        c1 = cyc;
        a  = 8'h04;
        b  = 8'h09;
        exp_q.push_back(model(8'h04, 8'h09));
        accept_cnt++;
        tick();
        start = 1'b0;
        wait_done(n);
        check("b2b_spacing", cyc - c1, 32'd9);
        tick();

        // Reset aborts an in-flight op.
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'h15;
        tick();
        start = 1'b0;
        repeat (2) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_diff", {24'b0, diff}, 32'd0);
        check("abort_borrow", {31'b0, borrow}, 32'd0);
        repeat (12) tick();
        issue(8'h07, 8'h02);
        wait_idle();

        // Randomised sweep, random gaps (including back-to-back).
        for (int i = 0; i < 500; i++) begin
            issue(W'($urandom), W'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) tick();
        end
        wait_idle();
        repeat (4) tick();

        check("queue_drained", exp_q.size(), 32'd0);
        check("done_count", done_cnt, accept_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
